vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised, run-time reprogrammable VGA raster timing generator. Successor to the
//  fixed 640x480 controller. Adds sync polarity control, a pixel-clock enable, a
//  frame-boundary mode switch via valid/ready handshake, and a pipeline delay on the
//  syncs so that sync/video_on line up with pixel data from a framebuffer fetch.
//  Sits between the pixel clock domain and the framebuffer reader / DAC output stage.
// PARAMETERS
//  CW        12   counter/coordinate width; every timing total must be <= 2**CW
//  PIPE_DLY  2    pixel-enable cycles from x/y coordinate to matching hsync/vsync/video_on (0..7)
//  HS_POL    1'b0 hsync asserted level (0 = active-low, as in standard 640x480)
//  VS_POL    1'b0 vsync asserted level
//  DEF_*     640/16/96/48 (H), 480/10/2/33 (V) reset timing: HVID,HFP,HS,HBP,VVID,VFP,VS,VBP
// PORTS
//  clk_25      in   1     pixel-domain clock
//  n_rst       in   1     asynchronous active-low reset
//  pix_en      in   1     pixel clock enable; all state advances only when high
//  cfg_valid   in   1     new timing offered
//  cfg_ready   out  1     generator can accept timing (state RUN)
//  cfg_timing  in   8*CW  vga_pkg::vga_timing_t {hvid,hfp,hs,hbp,vvid,vfp,vs,vbp}
//  cfg_err     out  1     1-cycle pulse: offered timing rejected
//  x_coord     out  CW    horizontal counter (fetch address, undelayed)
//  y_coord     out  CW    vertical counter (undelayed)
//  fetch_en    out  1     x_coord/y_coord inside the active area (undelayed)
//  hsync       out  1     delayed by PIPE_DLY, polarity HS_POL
//  vsync       out  1     delayed by PIPE_DLY, polarity VS_POL
//  video_on    out  1     delayed by PIPE_DLY, high in active area
//  line_start  out  1     pulse with pix_en when x_coord wraps to 0
//  frame_start out  1     pulse with pix_en when x_coord and y_coord both wrap to 0
//  frame_cnt   out  16    frames completed since reset; wraps at 2**16
// BEHAVIOUR
//  - Reset: x/y = 0, active timing = DEF_*, state RUN, cfg_ready = 1, cfg_err = 0,
//    frame_cnt = 0, line_start = frame_start = 0, fetch_en = 0, video_on = 0.
//    hsync/vsync and every delay stage are at their deasserted level.
//  - Count: with pix_en, x increments. x == HT-1 wraps to 0, and y increments.
//    y == VT-1 at that wrap also wraps to 0. HT = hvid+hfp+hs+hbp; VT likewise.
//  - Without pix_en, nothing changes, including the delay line and pulses.
//  - Decode (undelayed, combinational on x/y): fetch_en = x<hvid && y<vvid.
//    hs_raw = hvid+hfp <= x < hvid+hfp+hs; vs_raw likewise on y.
//  - Delay: {hs_raw,vs_raw,fetch_en} enter a PIPE_DLY-deep shift register on each pix_en.
//    The outputs are its last stage. PIPE_DLY = 0 means registered 1-cycle decode,
//    the same as the previous controller. All outputs are registered.
//  - Config FSM, states RUN and PEND:
//    RUN : cfg_ready = 1. On cfg_valid, check legality. Every field >= 1 and HT, VT <= 2**CW.
//          Legal: latch into the shadow register, go to PEND.
//          Illegal: pulse cfg_err, stay in RUN; the active timing is untouched.
//    PEND: cfg_ready = 0. On the last pixel of the frame (x==HT-1, y==VT-1, pix_en),
//          shadow becomes active, x/y become 0, state returns to RUN.
//  - Frame boundary: at the PEND swap, frame_start still pulses and frame_cnt increments.
//    The delay line is not flushed; its tail drains old-mode levels.
//  - Simultaneous: cfg_valid on the very last-pixel cycle while in RUN is accepted
//    into PEND. It takes effect at the next frame end, never the current one.
//  - Reset mid-frame or in PEND: shadow is discarded, DEF_* timing is restored.
// STRUCTURE
//  - vga_pkg: vga_timing_t packed struct (parametrised by CW via typedef in package with
//    CW_MAX = 12), state enum {RUN, PEND}, DEF_* constants.
//  - One sub-module: vga_sync_delay (PIPE_DLY-deep, enable-gated, reset-to-deasserted shift
//    register, width 3). Counters, decode and FSM live in vga_timing_gen.
// TESTING
//  1. Reset, pix_en = 1, default timing: hsync low for x in 656..751 (seen 2 cycles later).
//     video_on high 640x480. frame_start every 420000 cycles; frame_cnt increments.
//  2. pix_en toggling 1/0: outputs hold on pix_en = 0 cycles. The period is 840000 clk_25 cycles.
//  3. Mid-frame legal cfg 320/8/48/24, 240/5/1/16: cfg_ready drops. The old timing finishes
//     the frame. The next frame has HT = 400, VT = 262, and cfg_ready returns high.
//  4. cfg with hs = 0, and a second with HT = 5000 at CW = 12: cfg_err pulses and timing is unchanged.
//  5. Assert n_rst while in PEND: all outputs take reset values. After release, the timing is default.
//  6. cfg_valid exactly on the last pixel: no switch at that boundary; the switch occurs one frame later.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types, reset timing and helper functions for the VGA raster timing generator.
package vga_pkg;

    localparam int CW_MAX = 12;

    typedef logic [CW_MAX-1:0] crd_t;
    typedef logic [CW_MAX+1:0] sum_t;   // four CW_MAX fields summed never overflow

    typedef struct packed {
        crd_t hvid;
        crd_t hfp;
        crd_t hs;
        crd_t hbp;
        crd_t vvid;
        crd_t vfp;
        crd_t vs;
        crd_t vbp;
    } vga_timing_t;

    typedef enum logic {RUN = 1'b0, PEND = 1'b1} cfg_state_t;

    localparam int DEF_HVID = 640;
    localparam int DEF_HFP  = 16;
    localparam int DEF_HS   = 96;
    localparam int DEF_HBP  = 48;
    localparam int DEF_VVID = 480;
    localparam int DEF_VFP  = 10;
    localparam int DEF_VS   = 2;
    localparam int DEF_VBP  = 33;

    function automatic sum_t h_total(input vga_timing_t t);
        return sum_t'(t.hvid) + sum_t'(t.hfp) + sum_t'(t.hs) + sum_t'(t.hbp);
    endfunction

    function automatic sum_t v_total(input vga_timing_t t);
        return sum_t'(t.vvid) + sum_t'(t.vfp) + sum_t'(t.vs) + sum_t'(t.vbp);
    endfunction

    // Sync window is [vid+fp, vid+fp+len).
    function automatic logic in_win(input crd_t c, input crd_t vid, input crd_t fp, input crd_t len);
        sum_t lo;
        lo = sum_t'(vid) + sum_t'(fp);
        return (sum_t'(c) >= lo) && (sum_t'(c) < lo + sum_t'(len));
    endfunction

    function automatic logic legal(input vga_timing_t t, input int cw);
        logic nz;
        nz = (t.hvid != '0) && (t.hfp != '0) && (t.hs != '0) && (t.hbp != '0) &&
             (t.vvid != '0) && (t.vfp != '0) && (t.vs != '0) && (t.vbp != '0);
        return nz && (h_total(t) <= (sum_t'(1) << cw)) && (v_total(t) <= (sum_t'(1) << cw));
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing reprogramming channel: valid/ready offer of a new timing set plus a reject pulse.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_err;
    vga_timing_t cfg_timing;

    modport master (output cfg_valid, cfg_timing, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_timing, output cfg_ready, cfg_err);

endinterface

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register that aligns sync/video levels with the framebuffer fetch latency.
module vga_sync_delay #(
    parameter int             DEPTH   = 2,
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [DEPTH-1:0][W-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= RST_VAL;
        end else if (en_i) begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Run-time reprogrammable VGA raster timing generator: counters, decode, frame-boundary
// timing swap and the sync alignment delay.
module vga_timing_gen #(
    parameter int   CW       = 12,
    parameter int   PIPE_DLY = 2,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   DEF_HVID = vga_pkg::DEF_HVID,
    parameter int   DEF_HFP  = vga_pkg::DEF_HFP,
    parameter int   DEF_HS   = vga_pkg::DEF_HS,
    parameter int   DEF_HBP  = vga_pkg::DEF_HBP,
    parameter int   DEF_VVID = vga_pkg::DEF_VVID,
    parameter int   DEF_VFP  = vga_pkg::DEF_VFP,
    parameter int   DEF_VS   = vga_pkg::DEF_VS,
    parameter int   DEF_VBP  = vga_pkg::DEF_VBP
) (
    input  logic            clk_25,
    input  logic            n_rst,
    input  logic            pix_en,
    vga_timing_gen_if.slave cfg,
    output logic [CW-1:0]   x_coord,
    output logic [CW-1:0]   y_coord,
    output logic            fetch_en,
    output logic            hsync,
    output logic            vsync,
    output logic            video_on,
    output logic            line_start,
    output logic            frame_start,
    output logic [15:0]     frame_cnt
);
    import vga_pkg::*;

    // A zero-length delay still has to be registered, so it collapses to one stage.
    localparam int DEPTH = (PIPE_DLY < 1) ? 1 : PIPE_DLY;
    localparam vga_timing_t DEF_T = {crd_t'(DEF_HVID), crd_t'(DEF_HFP), crd_t'(DEF_HS),
                                     crd_t'(DEF_HBP), crd_t'(DEF_VVID), crd_t'(DEF_VFP),
                                     crd_t'(DEF_VS), crd_t'(DEF_VBP)};

    cfg_state_t  st_q, st_d;
    vga_timing_t act_q, act_d, shd_q, shd_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [15:0] fc_q, fc_d;
    logic        fe_q, fe_d, ls_q, ls_d, fs_q, fs_d, err_q, err_d;
    sum_t        ht, vt;
    logic        eol, eof;
    logic        hs_raw, vs_raw, act_raw;
    logic [2:0]  dly_d, dly_q;

    always_comb begin
        ht      = h_total(act_q);
        vt      = v_total(act_q);
        eol     = (sum_t'(x_q) == ht - sum_t'(1));
        eof     = eol && (sum_t'(y_q) == vt - sum_t'(1));
        hs_raw  = in_win(crd_t'(x_q), act_q.hvid, act_q.hfp, act_q.hs);
        vs_raw  = in_win(crd_t'(y_q), act_q.vvid, act_q.vfp, act_q.vs);
        act_raw = (crd_t'(x_q) < act_q.hvid) && (crd_t'(y_q) < act_q.vvid);
        dly_d   = {hs_raw ? HS_POL : ~HS_POL, vs_raw ? VS_POL : ~VS_POL, act_raw};
    end

    always_comb begin
        st_d  = st_q;
        act_d = act_q;
        shd_d = shd_q;
        err_d = 1'b0;
        x_d   = x_q;
        y_d   = y_q;
        fc_d  = fc_q;
        fe_d  = fe_q;
        ls_d  = ls_q;
        fs_d  = fs_q;
        // The handshake runs at clock rate; only the raster itself waits for pix_en.
        case (st_q)
            RUN: begin
                if (cfg.cfg_valid) begin
                    if (legal(cfg.cfg_timing, CW)) begin
                        shd_d = cfg.cfg_timing;
                        st_d  = PEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PEND: begin
                if (pix_en && eof) begin
                    act_d = shd_q;
                    st_d  = RUN;
                end
            end
            default: st_d = RUN;
        endcase
        if (pix_en) begin
            x_d  = eol ? '0 : x_q + CW'(1);
            y_d  = eof ? '0 : (eol ? y_q + CW'(1) : y_q);
            ls_d = eol;
            fs_d = eof;
            if (eof) fc_d = fc_q + 16'd1;
            // Look ahead with the next coordinates so fetch_en lines up with x/y.
            fe_d = (crd_t'(x_d) < act_d.hvid) && (crd_t'(y_d) < act_d.vvid);
        end
    end

    always_ff @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) begin
            st_q  <= RUN;
            act_q <= DEF_T;
            shd_q <= DEF_T;
            x_q   <= '0;
            y_q   <= '0;
            fc_q  <= '0;
            fe_q  <= 1'b0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            act_q <= act_d;
            shd_q <= shd_d;
            x_q   <= x_d;
            y_q   <= y_d;
            fc_q  <= fc_d;
            fe_q  <= fe_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
            err_q <= err_d;
        end
    end

    vga_sync_delay #(
        .DEPTH   (DEPTH),
        .W       (3),
        .RST_VAL ({~HS_POL, ~VS_POL, 1'b0})
    ) u_dly (
        .clk   (clk_25),
        .rst_n (n_rst),
        .en_i  (pix_en),
        .d_i   (dly_d),
        .q_o   (dly_q)
    );

    assign {hsync, vsync, video_on} = dly_q;
    assign x_coord       = x_q;
    assign y_coord       = y_q;
    assign fetch_en      = fe_q;
    assign line_start    = ls_q;
    assign frame_start   = fs_q;
    assign frame_cnt     = fc_q;
    assign cfg.cfg_ready = (st_q == RUN);
    assign cfg.cfg_err   = err_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a shrunken reset timing (HT=15, VT=8).
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic        clk_25 = 1'b0;
    logic        n_rst;
    logic        pix_en;
    logic [11:0] x_coord, y_coord;
    logic        fetch_en, hsync, vsync, video_on, line_start, frame_start;
    logic [15:0] frame_cnt;
    int          checks = 0;
    int          errors = 0;

    vga_timing_gen_if cfg_if();

    vga_timing_gen #(
        .CW(12), .PIPE_DLY(2), .HS_POL(1'b0), .VS_POL(1'b1),
        .DEF_HVID(8), .DEF_HFP(2), .DEF_HS(3), .DEF_HBP(2),
        .DEF_VVID(4), .DEF_VFP(1), .DEF_VS(2), .DEF_VBP(1)
    ) dut (
        .clk_25      (clk_25),
        .n_rst       (n_rst),
        .pix_en      (pix_en),
        .cfg         (cfg_if),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .fetch_en    (fetch_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk_25 = ~clk_25;

    typedef struct {
        int steps; int tog;
        int x; int y; int hs; int vs; int vo; int fe; int ls; int fs; int fc;
    } vec_t;

    function automatic vga_timing_t mk(int a, int b, int c, int d, int e, int f, int g, int h);
        return {crd_t'(a), crd_t'(b), crd_t'(c), crd_t'(d), crd_t'(e), crd_t'(f), crd_t'(g), crd_t'(h)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Called at a negedge: inputs change here, the DUT samples them on the next posedge.
    task automatic tick(input logic pe);
        pix_en = pe;
        @(posedge clk_25);
        @(negedge clk_25);
    endtask

    task automatic adv(input int n, input int tog);
        repeat (n) begin
            tick(1'b1);
            if (tog != 0) tick(1'b0);
        end
    endtask

    task automatic send_cfg(input vga_timing_t t, input logic pe);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_timing = t;
        tick(pe);
        cfg_if.cfg_valid  = 1'b0;
    endtask

    task automatic chk_xy(input string tag, input int x, input int y);
        chk({tag, ".x"}, int'(x_coord), x);
        chk({tag, ".y"}, int'(y_coord), y);
    endtask

    task automatic chk_vec(input string tag, input vec_t v);
        chk_xy(tag, v.x, v.y);
        chk({tag, ".hsync"},    int'(hsync),       v.hs);
        chk({tag, ".vsync"},    int'(vsync),       v.vs);
        chk({tag, ".video_on"}, int'(video_on),    v.vo);
        chk({tag, ".fetch_en"}, int'(fetch_en),    v.fe);
        chk({tag, ".line_st"},  int'(line_start),  v.ls);
        chk({tag, ".frame_st"}, int'(frame_start), v.fs);
        chk({tag, ".frame_cnt"},int'(frame_cnt),   v.fc);
    endtask

    vga_timing_t t_new, t_hs0, t_big;

    initial begin
        vec_t vecs[13];
        //           steps tog   x  y hs vs vo fe ls fs fc
        vecs[0]  = '{  0,  0,    0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{  1,  0,    1, 0, 1, 0, 0, 1, 0, 0, 0};
        vecs[2]  = '{  1,  0,    2, 0, 1, 0, 1, 1, 0, 0, 0};
        vecs[3]  = '{ 10,  0,   12, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{  3,  0,    0, 1, 1, 0, 0, 1, 1, 0, 0};
        vecs[5]  = '{  1,  0,    1, 1, 1, 0, 0, 1, 0, 0, 0};
        vecs[6]  = '{  1,  0,    2, 1, 1, 0, 1, 1, 0, 0, 0};
        vecs[7]  = '{ 60,  0,    2, 5, 1, 1, 0, 0, 0, 0, 0};
        vecs[8]  = '{ 43,  0,    0, 0, 1, 0, 0, 1, 1, 1, 1};
        vecs[9]  = '{  1,  0,    1, 0, 1, 0, 0, 1, 0, 0, 1};
        vecs[10] = '{  1,  0,    2, 0, 1, 0, 1, 1, 0, 0, 1};
        vecs[11] = '{120,  1,    2, 0, 1, 0, 1, 1, 0, 0, 2};
        vecs[12] = '{ 13,  1,    0, 1, 1, 0, 0, 1, 1, 0, 2};

        t_new = mk(4, 1, 2, 1, 2, 1, 1, 1);          // HT=8, VT=5
        t_hs0 = mk(8, 2, 0, 2, 4, 1, 2, 1);
        t_big = mk(4000, 500, 400, 100, 4, 1, 2, 1); // HT=5000 > 4096

        n_rst = 1'b0;
        pix_en = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_timing = mk(8, 2, 3, 2, 4, 1, 2, 1);
        repeat (2) @(negedge clk_25);
        chk("rst.cfg_ready", int'(cfg_if.cfg_ready), 1);
        chk("rst.cfg_err",   int'(cfg_if.cfg_err),   0);
        n_rst = 1'b1;

        // Raster walk, continuous and with pix_en toggling 1/0.
        for (int i = 0; i < 13; i++) begin
            adv(vecs[i].steps, vecs[i].tog);
            chk_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Mid-frame legal reprogram: old timing finishes the frame.
        send_cfg(t_new, 1'b0);
        chk("cfg.ready_drop", int'(cfg_if.cfg_ready), 0);
        chk("cfg.err_none",   int'(cfg_if.cfg_err),   0);
        adv(104, 0);
        chk_xy("cfg.oldend", 14, 7);
        chk("cfg.oldend.ready", int'(cfg_if.cfg_ready), 0);
        adv(1, 0);
        chk_xy("cfg.swap", 0, 0);
        chk("cfg.swap.fs",    int'(frame_start), 1);
        chk("cfg.swap.fc",    int'(frame_cnt),   3);
        chk("cfg.swap.ready", int'(cfg_if.cfg_ready), 1);
        adv(1, 0);
        chk("cfg.tail.vo", int'(video_on), 0);
        adv(1, 0);
        chk("cfg.new.vo",  int'(video_on), 1);
        adv(5, 0);
        chk_xy("cfg.m7", 7, 0);
        chk("cfg.m7.hsync", int'(hsync), 0);
        chk("cfg.m7.fe",    int'(fetch_en), 0);
        adv(1, 0);
        chk_xy("cfg.m8", 0, 1);
        chk("cfg.m8.ls", int'(line_start), 1);
        adv(32, 0);
        chk_xy("cfg.m40", 0, 0);
        chk("cfg.m40.fs", int'(frame_start), 1);
        chk("cfg.m40.fc", int'(frame_cnt),   4);

        // Illegal offers are rejected and leave the running timing alone.
        send_cfg(t_hs0, 1'b0);
        chk("ill.hs0.err",   int'(cfg_if.cfg_err),   1);
        chk("ill.hs0.ready", int'(cfg_if.cfg_ready), 1);
        tick(1'b0);
        chk("ill.hs0.errclr", int'(cfg_if.cfg_err), 0);
        send_cfg(t_big, 1'b0);
        chk("ill.big.err",   int'(cfg_if.cfg_err),   1);
        chk("ill.big.ready", int'(cfg_if.cfg_ready), 1);
        tick(1'b0);
        adv(8, 0);
        chk_xy("ill.keep", 0, 1);
        chk("ill.keep.ls", int'(line_start), 1);

        // Reset while a new timing is pending.
        send_cfg(t_new, 1'b0);
        chk("prst.pend", int'(cfg_if.cfg_ready), 0);
        adv(3, 0);
        n_rst = 1'b0;
        #1;
        chk_xy("prst", 0, 0);
        chk("prst.hsync", int'(hsync),       1);
        chk("prst.vsync", int'(vsync),       0);
        chk("prst.vo",    int'(video_on),    0);
        chk("prst.fe",    int'(fetch_en),    0);
        chk("prst.ls",    int'(line_start),  0);
        chk("prst.fs",    int'(frame_start), 0);
        chk("prst.fc",    int'(frame_cnt),   0);
        chk("prst.ready", int'(cfg_if.cfg_ready), 1);
        chk("prst.err",   int'(cfg_if.cfg_err),   0);
        @(negedge clk_25);
        n_rst = 1'b1;
        adv(15, 0);
        chk_xy("prst.line", 0, 1);
        adv(105, 0);
        chk_xy("prst.frame", 0, 0);
        chk("prst.frame.fc",    int'(frame_cnt), 1);
        chk("prst.frame.ready", int'(cfg_if.cfg_ready), 1);

        // Offer landing exactly on the last pixel waits a whole frame.
        adv(119, 0);
        chk_xy("last.pre", 14, 7);
        send_cfg(t_new, 1'b1);
        chk_xy("last.b0", 0, 0);
        chk("last.b0.fc",    int'(frame_cnt), 2);
        chk("last.b0.ready", int'(cfg_if.cfg_ready), 0);
        adv(15, 0);
        chk_xy("last.oldline", 0, 1);
        adv(105, 0);
        chk_xy("last.b1", 0, 0);
        chk("last.b1.fc",    int'(frame_cnt), 3);
        chk("last.b1.ready", int'(cfg_if.cfg_ready), 1);
        adv(8, 0);
        chk_xy("last.newline", 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
